// File: rtl/console_pkg.sv
// Shared console geometry and VGA 640x480@60 timing constants, used by both the
// console writer and the text renderer.
package console_pkg;

  localparam int unsigned COLS             = 80;
  localparam int unsigned ROWS             = 30;
  localparam int unsigned CONSOLE_ADDR_MAX = COLS * ROWS - 1;

  localparam int unsigned VGA_H_VISIBLE = 640;
  localparam int unsigned VGA_H_FRONT   = 16;
  localparam int unsigned VGA_H_SYNC    = 96;
  localparam int unsigned VGA_H_BACK    = 48;
  localparam int unsigned VGA_V_VISIBLE = 480;
  localparam int unsigned VGA_V_FRONT   = 10;
  localparam int unsigned VGA_V_SYNC    = 2;
  localparam int unsigned VGA_V_BACK    = 33;

  localparam int unsigned VGA_H_SYNC_START = VGA_H_VISIBLE + VGA_H_FRONT;
  localparam int unsigned VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;
  localparam int unsigned VGA_H_TOTAL      = VGA_H_SYNC_END + VGA_H_BACK;
  localparam int unsigned VGA_V_SYNC_START = VGA_V_VISIBLE + VGA_V_FRONT;
  localparam int unsigned VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;
  localparam int unsigned VGA_V_TOTAL      = VGA_V_SYNC_END + VGA_V_BACK;

  // Per-pixel control carried down the render pipeline alongside the fetches.
  typedef struct packed {
    logic       vis;
    logic       h_pulse;
    logic       v_pulse;
    logic [2:0] col;
  } pix_ctl_t;

endpackage

// File: rtl/vga_timing.sv
// Raster h/v counters with combinational visible and (active-high) sync-pulse flags,
// all valid in the same cycle as the counter values.
module vga_timing
  import console_pkg::*;
#(
  parameter int unsigned H_VISIBLE = VGA_H_VISIBLE,
  parameter int unsigned H_FRONT   = VGA_H_FRONT,
  parameter int unsigned H_SYNC    = VGA_H_SYNC,
  parameter int unsigned H_BACK    = VGA_H_BACK,
  parameter int unsigned V_VISIBLE = VGA_V_VISIBLE,
  parameter int unsigned V_FRONT   = VGA_V_FRONT,
  parameter int unsigned V_SYNC    = VGA_V_SYNC,
  parameter int unsigned V_BACK    = VGA_V_BACK
) (
  input  logic       clock,
  input  logic       resetn,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       visible,
  output logic       h_pulse,
  output logic       v_pulse
);

  localparam int unsigned HSyncStart = H_VISIBLE + H_FRONT;
  localparam int unsigned HSyncEnd   = HSyncStart + H_SYNC;
  localparam int unsigned HLast      = HSyncEnd + H_BACK - 1;
  localparam int unsigned VSyncStart = V_VISIBLE + V_FRONT;
  localparam int unsigned VSyncEnd   = VSyncStart + V_SYNC;
  localparam int unsigned VLast      = VSyncEnd + V_BACK - 1;

  logic [9:0] h_q, h_d, v_q, v_d;

  always_comb begin
    h_d = h_q + 10'd1;
    v_d = v_q;
    if (h_q == 10'(HLast)) begin
      h_d = '0;
      v_d = (v_q == 10'(VLast)) ? '0 : v_q + 10'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h_cnt   = h_q;
  assign v_cnt   = v_q;
  assign visible = (h_q < 10'(H_VISIBLE)) && (v_q < 10'(V_VISIBLE));
  assign h_pulse = (h_q >= 10'(HSyncStart)) && (h_q < 10'(HSyncEnd));
  assign v_pulse = (v_q >= 10'(VSyncStart)) && (v_q < 10'(VSyncEnd));

endmodule

// File: rtl/console_text_renderer.sv
// Renders the 80x30 character buffer as 640x480 VGA through an 8x16 font ROM,
// with a fixed 3-cycle counter-to-pin pipeline (char fetch, font fetch, output).
module console_text_renderer
  import console_pkg::*;
#(
  parameter int unsigned H_VISIBLE = VGA_H_VISIBLE,
  parameter int unsigned H_FRONT   = VGA_H_FRONT,
  parameter int unsigned H_SYNC    = VGA_H_SYNC,
  parameter int unsigned H_BACK    = VGA_H_BACK,
  parameter int unsigned V_VISIBLE = VGA_V_VISIBLE,
  parameter int unsigned V_FRONT   = VGA_V_FRONT,
  parameter int unsigned V_SYNC    = VGA_V_SYNC,
  parameter int unsigned V_BACK    = VGA_V_BACK
) (
  input  logic        clock,
  input  logic        resetn,
  output logic [11:0] char_addr,
  input  logic [7:0]  char_data,
  output logic [11:0] font_addr,
  input  logic [7:0]  font_data,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic        pixel
);

  logic [9:0] h_cnt, v_cnt;
  logic       vis0, h_pulse0, v_pulse0;

  vga_timing #(
    .H_VISIBLE (H_VISIBLE),
    .H_FRONT   (H_FRONT),
    .H_SYNC    (H_SYNC),
    .H_BACK    (H_BACK),
    .V_VISIBLE (V_VISIBLE),
    .V_FRONT   (V_FRONT),
    .V_SYNC    (V_SYNC),
    .V_BACK    (V_BACK)
  ) u_timing (
    .clock   (clock),
    .resetn  (resetn),
    .h_cnt   (h_cnt),
    .v_cnt   (v_cnt),
    .visible (vis0),
    .h_pulse (h_pulse0),
    .v_pulse (v_pulse0)
  );

  // Stage 0: cell address = row*80 + col, with *80 as two shifts.
  logic [11:0] cell_row, cell_addr;
  assign cell_row  = {6'd0, v_cnt[9:4]};
  assign cell_addr = (cell_row << 6) + (cell_row << 4) + {5'd0, h_cnt[9:3]};
  assign char_addr = vis0 ? cell_addr : '0;

  pix_ctl_t   s1_q, s2_q;
  logic [3:0] row1_q;
  logic       run1_q;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      s1_q   <= '0;
      s2_q   <= '0;
      row1_q <= '0;
      run1_q <= 1'b0;
    end else begin
      s1_q   <= '{vis: vis0, h_pulse: h_pulse0, v_pulse: v_pulse0, col: h_cnt[2:0]};
      s2_q   <= s1_q;
      row1_q <= v_cnt[3:0];
      run1_q <= 1'b1;
    end
  end

  // Held at 0 until the first post-reset char fetch has landed.
  assign font_addr = run1_q ? {char_data, row1_q} : '0;

  logic pixel_d, pixel_q, video_on_q, hsync_q, vsync_q;

  always_comb begin
    pixel_d = s2_q.vis & font_data[3'd7 - s2_q.col];
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      pixel_q    <= 1'b0;
      video_on_q <= 1'b0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
    end else begin
      pixel_q    <= pixel_d;
      video_on_q <= s2_q.vis;
      hsync_q    <= ~s2_q.h_pulse;
      vsync_q    <= ~s2_q.v_pulse;
    end
  end

  assign pixel    = pixel_q;
  assign video_on = video_on_q;
  assign hsync    = hsync_q;
  assign vsync    = vsync_q;

endmodule
